// File: rtl/uart_tx_pkg.sv
// Shared types and constants for the configurable UART transmitter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package uart_tx_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_e;

  localparam int   MIN_DATA_LEN = 5;
  localparam logic PAR_EVEN     = 1'b0;
  localparam logic PAR_ODD      = 1'b1;

  // Fold an out-of-range data length into MIN_DATA_LEN..max_len.
  function automatic logic [3:0] clamp_len(input logic [3:0] len, input int max_len);
    if (int'(len) < MIN_DATA_LEN) return 4'(MIN_DATA_LEN);
    if (int'(len) > max_len)      return 4'(max_len);
    return len;
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period prescaler: pulses tick on the last clk cycle of every bit.
// Latency: tick after max(prescale,1) cycles from clear or the previous tick.
// Backpressure: none; free-running while clear is low.
module uart_baud_tick #(
  parameter int PRESCALE_W = 8
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  clear,
  input  logic [PRESCALE_W-1:0] prescale,
  output logic                  tick
);

  logic [PRESCALE_W-1:0] cnt;
  logic [PRESCALE_W-1:0] last;

  // A prescale of 0 behaves like 1, so the terminal count is 0 in both cases.
  assign last = (prescale == '0) ? '0 : prescale - PRESCALE_W'(1);
  assign tick = (cnt == last);

  // Count 0..last, wrapping on tick; clear parks the counter at 0 between frames.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt <= '0;
    end else if (clear || tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + PRESCALE_W'(1);
    end
  end

endmodule

// File: rtl/uart_tx_cfg.sv
// UART transmitter with one-entry holding buffer and per-word frame config.
// Latency: start bit on the line one cycle after the word lands in an idle buffer.
// Backpressure: in_ready low while the holding buffer is occupied.
module uart_tx_cfg
  import uart_tx_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int PRESCALE_W = 8
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic [DATA_WIDTH-1:0] p_data,
  input  logic                  data_valid,
  output logic                  in_ready,
  input  logic [3:0]            data_len,
  input  logic                  par_en,
  input  logic                  par_type,
  input  logic                  stop2,
  input  logic [PRESCALE_W-1:0] prescale,
  output logic                  tx_out,
  output logic                  busy
);

  typedef struct packed {
    logic [DATA_WIDTH-1:0] data;
    logic [3:0]            len;
    logic                  par_en;
    logic                  par_type;
    logic                  stop2;
  } word_t;

  tx_state_e             state;
  logic                  buf_full;
  word_t                 buf_q;
  word_t                 in_word;
  word_t                 next_word;
  logic                  hs;
  logic                  tick;
  logic                  last_stop;
  logic                  start_frame;
  logic                  par_next;

  logic [DATA_WIDTH-1:0] shreg;
  logic [3:0]            bit_cnt;
  logic [3:0]            f_len;
  logic                  f_par_en;
  logic                  f_par;
  logic                  f_stop2;
  logic                  stop_cnt;
  logic [PRESCALE_W-1:0] prs_q;

  assign in_ready = !buf_full;
  assign hs       = data_valid && in_ready;
  assign in_word  = '{data: p_data, len: clamp_len(data_len, DATA_WIDTH),
                      par_en: par_en, par_type: par_type, stop2: stop2};

  // A word arriving on the final stop cycle bypasses the buffer so frames abut.
  assign next_word   = buf_full ? buf_q : in_word;
  assign last_stop   = (state == STOP) && tick && (!f_stop2 || stop_cnt);
  assign start_frame = ((state == IDLE) && buf_full) || (last_stop && (buf_full || hs));

  uart_baud_tick #(.PRESCALE_W(PRESCALE_W)) u_baud (
    .clk      (clk),
    .rstn     (rstn),
    .clear    (state == IDLE),
    .prescale (prs_q),
    .tick     (tick)
  );

  // Parity over the active data bits of the word about to go on the line.
  always_comb begin
    par_next = (next_word.par_type == PAR_ODD);
    for (int i = 0; i < DATA_WIDTH; i++) begin
      if (i < int'(next_word.len)) par_next = par_next ^ next_word.data[i];
    end
  end

  // Holding buffer: fill on handshake, empty when the shifter takes the word.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      buf_full <= 1'b0;
      buf_q    <= '0;
    end else if (hs && !start_frame) begin
      buf_full <= 1'b1;
      buf_q    <= in_word;
    end else if (start_frame) begin
      buf_full <= 1'b0;
    end
  end

  // Frame FSM with registered line and busy outputs.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state    <= IDLE;
      tx_out   <= 1'b1;
      busy     <= 1'b0;
      shreg    <= '0;
      bit_cnt  <= '0;
      f_len    <= '0;
      f_par_en <= 1'b0;
      f_par    <= 1'b0;
      f_stop2  <= 1'b0;
      stop_cnt <= 1'b0;
      prs_q    <= '0;
    end else if (start_frame) begin
      state    <= START;
      tx_out   <= 1'b0;
      busy     <= 1'b1;
      shreg    <= next_word.data;
      bit_cnt  <= '0;
      f_len    <= next_word.len;
      f_par_en <= next_word.par_en;
      f_par    <= par_next;
      f_stop2  <= next_word.stop2;
      stop_cnt <= 1'b0;
      prs_q    <= prescale;
    end else if (tick) begin
      case (state)
        START: begin
          state  <= DATA;
          tx_out <= shreg[0];
        end
        DATA: begin
          if (bit_cnt == f_len - 4'd1) begin
            if (f_par_en) begin
              state  <= PARITY;
              tx_out <= f_par;
            end else begin
              state  <= STOP;
              tx_out <= 1'b1;
            end
          end else begin
            bit_cnt <= bit_cnt + 4'd1;
            shreg   <= shreg >> 1;
            tx_out  <= shreg[1];
          end
        end
        PARITY: begin
          state  <= STOP;
          tx_out <= 1'b1;
        end
        STOP: begin
          if (f_stop2 && !stop_cnt) begin
            stop_cnt <= 1'b1;
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Self-checking bench for uart_tx_cfg: table of frames plus hand-built corner sequences.
// Latency: n/a.
// Backpressure: n/a.
module tb_uart_tx_cfg;

  localparam int DW = 9;
  localparam int PW = 8;

  logic          clk = 1'b0;
  logic          rstn;
  logic [DW-1:0] p_data;
  logic          data_valid;
  logic          in_ready;
  logic [3:0]    data_len;
  logic          par_en;
  logic          par_type;
  logic          stop2;
  logic [PW-1:0] prescale;
  logic          tx_out;
  logic          busy;

  uart_tx_cfg #(.DATA_WIDTH(DW), .PRESCALE_W(PW)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .p_data     (p_data),
    .data_valid (data_valid),
    .in_ready   (in_ready),
    .data_len   (data_len),
    .par_en     (par_en),
    .par_type   (par_type),
    .stop2      (stop2),
    .prescale   (prescale),
    .tx_out     (tx_out),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // Inputs plus the expected effective length, parity bit and bit period.
  typedef struct {
    logic [DW-1:0] data;
    logic [3:0]    dlen;
    logic          pe;
    logic          pt;
    logic          s2;
    logic [PW-1:0] ps;
    int            exp_len;
    logic          exp_par;
    int            exp_p;
  } vec_t;

  vec_t sb[$];
  vec_t vecs[9];
  vec_t va, vb, vc, vd, ve, vf, vg;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_start = -1;
  int rise_cyc;
  int tgt;
  int tb_t;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input bit ok, input string name, input int act, input int exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic [DW-1:0] d, input int len, input bit pe, input bit pt,
                              input bit s2, input int ps, input int el, input bit ep, input int p);
    vec_t v;
    v.data = d; v.dlen = 4'(len); v.pe = pe; v.pt = pt; v.s2 = s2; v.ps = PW'(ps);
    v.exp_len = el; v.exp_par = ep; v.exp_p = p;
    return v;
  endfunction

  function automatic int frame_cycles(input vec_t v);
    return (2 + v.exp_len + int'(v.pe) + int'(v.s2)) * v.exp_p;
  endfunction

  task automatic drive(input vec_t v);
    p_data = v.data; data_len = v.dlen; par_en = v.pe; par_type = v.pt;
    stop2 = v.s2; prescale = v.ps;
  endtask

  // Offer a word; on an idle line also check the buffer-fill / start-bit latency.
  task automatic send(input vec_t v, input bit idle_chk);
    int t;
    @(negedge clk);
    drive(v);
    data_valid = 1'b1;
    t = 0;
    while (in_ready !== 1'b1 && t < 600) begin
      @(negedge clk);
      t++;
    end
    if (in_ready !== 1'b1) begin
      chk(1'b0, "handshake_timeout", t, 600);
      data_valid = 1'b0;
      return;
    end
    sb.push_back(v);
    @(posedge clk);
    #1 data_valid = 1'b0;
    if (idle_chk) begin
      chk(in_ready === 1'b0, "hs_ready_low", int'(in_ready), 0);
      chk(busy === 1'b0 && tx_out === 1'b1, "hs_line_idle", int'({tx_out, busy}), 2);
      @(posedge clk);
      #1;
      chk(in_ready === 1'b1, "pop_ready_high", int'(in_ready), 1);
      chk(busy === 1'b1 && tx_out === 1'b0, "start_latency", int'({tx_out, busy}), 1);
    end
  endtask

  // Pop the expected frame when its start bit appears and check every cycle of it.
  task automatic check_frame(input bit b2b, input bit already);
    vec_t f;
    logic seq[$];
    int   t;
    bit   ok;
    int   bad;
    if (!already) begin
      t = 0;
      do begin
        @(negedge clk);
        t++;
      end while (tx_out !== 1'b0 && t < 600);
      if (tx_out !== 1'b0) begin
        chk(1'b0, "start_timeout", t, 600);
        return;
      end
    end
    if (sb.size() == 0) begin
      chk(1'b0, "scoreboard_empty", 0, 1);
      return;
    end
    f = sb.pop_front();
    last_start = cyc;
    seq.push_back(1'b0);
    for (int i = 0; i < f.exp_len; i++) seq.push_back(f.data[i]);
    if (f.pe) seq.push_back(f.exp_par);
    seq.push_back(1'b1);
    if (f.s2) seq.push_back(1'b1);
    for (int k = 0; k < seq.size(); k++) begin
      ok = 1'b1;
      bad = 0;
      for (int c = 0; c < f.exp_p; c++) begin
        if (k != 0 || c != 0) @(negedge clk);
        if (tx_out !== seq[k] || busy !== 1'b1) begin
          ok = 1'b0;
          bad = int'({tx_out, busy});
        end
      end
      chk(ok, $sformatf("frame_bit%0d tx*2+busy", k), bad, int'({seq[k], 1'b1}));
    end
    @(negedge clk);
    if (b2b) chk(tx_out === 1'b0 && busy === 1'b1, "b2b_next_start", int'({tx_out, busy}), 1);
    else     chk(tx_out === 1'b1 && busy === 1'b0, "busy_fall", int'({tx_out, busy}), 2);
  endtask

  initial begin
    rstn = 1'b0; data_valid = 1'b0; p_data = '0; data_len = 4'd8;
    par_en = 1'b0; par_type = 1'b0; stop2 = 1'b0; prescale = 8'd4;

    repeat (3) @(negedge clk);
    chk(tx_out === 1'b1, "reset_tx_out", int'(tx_out), 1);
    chk(busy === 1'b0, "reset_busy", int'(busy), 0);
    chk(in_ready === 1'b1, "reset_in_ready", int'(in_ready), 1);
    @(negedge clk) rstn = 1'b1;

    //             data     len pe pt s2 ps  len par P
    vecs[0] = mk(9'h0A5,  8, 0, 0, 0, 4,  8, 0, 4);
    vecs[1] = mk(9'h1FF,  7, 1, 0, 0, 2,  7, 1, 2);
    vecs[2] = mk(9'h1FF,  7, 1, 1, 0, 2,  7, 0, 2);
    vecs[3] = mk(9'h00F,  8, 1, 0, 1, 3,  8, 0, 3);
    vecs[4] = mk(9'h03C,  6, 1, 1, 0, 1,  6, 1, 1);
    vecs[5] = mk(9'h096,  8, 0, 0, 0, 0,  8, 0, 1);
    vecs[6] = mk(9'h1E5,  3, 1, 0, 0, 2,  5, 0, 2);
    vecs[7] = mk(9'h155, 15, 1, 1, 0, 2,  9, 0, 2);
    vecs[8] = mk(9'h100,  9, 1, 0, 0, 2,  9, 1, 2);

    for (int i = 0; i < 9; i++) begin
      send(vecs[i], 1'b1);
      check_frame(1'b0, 1'b0);
    end

    // Second word accepted mid-frame: frames abut and in_ready rises at the second start.
    va = mk(9'h055, 8, 0, 0, 0, 2, 8, 0, 2);
    vb = mk(9'h033, 8, 1, 1, 0, 2, 8, 1, 2);
    send(va, 1'b1);
    rise_cyc = -1;
    fork
      begin
        check_frame(1'b1, 1'b0);
        check_frame(1'b0, 1'b1);
      end
      begin
        repeat (3) @(negedge clk);
        send(vb, 1'b0);
        chk(in_ready === 1'b0, "b2b_ready_low", int'(in_ready), 0);
        tb_t = 0;
        while (in_ready !== 1'b1 && tb_t < 600) begin
          @(negedge clk);
          tb_t++;
        end
        rise_cyc = cyc;
      end
    join
    chk(rise_cyc == last_start, "b2b_ready_rise_cycle", rise_cyc, last_start);

    // Handshake exactly on the last stop cycle still gives a back-to-back start.
    vc = mk(9'h0C3, 8, 0, 0, 0, 2, 8, 0, 2);
    vd = mk(9'h011, 6, 1, 0, 1, 3, 6, 0, 3);
    last_start = -1;
    send(vc, 1'b1);
    fork
      begin
        check_frame(1'b1, 1'b0);
        check_frame(1'b0, 1'b1);
      end
      begin
        tb_t = 0;
        while (last_start < 0 && tb_t < 600) begin
          @(negedge clk);
          tb_t++;
        end
        tgt = last_start + frame_cycles(vc) - 1;
        while (cyc < tgt && tb_t < 1200) begin
          @(negedge clk);
          tb_t++;
        end
        chk(in_ready === 1'b1 && busy === 1'b1, "last_stop_ready", int'({in_ready, busy}), 3);
        drive(vd);
        data_valid = 1'b1;
        sb.push_back(vd);
        @(posedge clk);
        #1 data_valid = 1'b0;
      end
    join

    // Config inputs change mid-frame; the frame on the line keeps its snapshot.
    ve = mk(9'h05A, 8, 0, 0, 1, 3, 8, 0, 3);
    send(ve, 1'b1);
    fork
      check_frame(1'b0, 1'b0);
      begin
        repeat (6) @(negedge clk);
        par_en = 1'b1; stop2 = 1'b0; prescale = 8'd1; data_len = 4'd5; par_type = 1'b1;
      end
    join

    // Asynchronous reset during DATA with a word pending in the buffer.
    vf = mk(9'h0A5, 8, 0, 0, 0, 4, 8, 0, 4);
    vg = mk(9'h0FF, 8, 1, 0, 0, 4, 8, 0, 4);
    send(vf, 1'b1);
    send(vg, 1'b0);
    repeat (14) @(negedge clk);
    chk(busy === 1'b1 && in_ready === 1'b0, "pre_reset_state", int'({busy, in_ready}), 2);
    #2 rstn = 1'b0;
    #1;
    chk(tx_out === 1'b1, "async_reset_tx_out", int'(tx_out), 1);
    chk(busy === 1'b0, "async_reset_busy", int'(busy), 0);
    chk(in_ready === 1'b1, "async_reset_in_ready", int'(in_ready), 1);
    sb.delete();
    @(negedge clk) rstn = 1'b1;
    send(vf, 1'b1);
    check_frame(1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_tx_cfg.md
# uart_tx_cfg

Parametrised next-generation UART transmitter for the UART subsystem. It accepts parallel words over a valid/ready handshake into a one-entry holding buffer, so consecutive frames go out back-to-back with no idle gap. Data length, parity and stop-bit count are selectable at runtime, and an internal prescaler sets the bit period. It drives the serial `tx_out` line from the system clock domain.

## Interface
- `DATA_WIDTH`, default 8: maximum data bits per frame; legal range 5–9.
- `PRESCALE_W`, default 8: width of the `prescale` input.

- `clk`  in  1  system clock.
- `rstn`  in  1  asynchronous active-low reset.
- `p_data`  in  `DATA_WIDTH`  parallel word; LSB is sent first.
- `data_valid`  in  1  word offered.
- `in_ready`  out  1  holding buffer empty; a transfer occurs when `data_valid && in_ready`.
- `data_len`  in  4  active data bits per frame; legal range 5..`DATA_WIDTH`.
- `par_en`  in  1  append a parity bit.
- `par_type`  in  1  0 = even parity, 1 = odd parity.
- `stop2`  in  1  0 = one stop bit, 1 = two stop bits.
- `prescale`  in  `PRESCALE_W`  clk cycles per bit; 0 is treated as 1.
- `tx_out`  out  1  serial line; idles high.
- `busy`  out  1  a frame is on the line.

## Operation
- **Holding buffer.**
  - One word plus its configuration snapshot (`data_len`, `par_en`, `par_type`, `stop2`).
  - Loads on handshake; `in_ready` = buffer empty.
  - The shifter pops it at the start of a frame.
- **FSM states:** IDLE, START, DATA, PARITY, STOP.
  - IDLE → START when the buffer is full.
  - START (`tx_out`=0, 1 bit) → DATA.
  - DATA: `data_len` bits, LSB first. Then → PARITY if `par_en`, else → STOP.
  - PARITY → STOP.
  - STOP: `tx_out`=1 for 1 or 2 bits. Then → START if the buffer is full, else → IDLE.
- **Parity.**
  - XOR over the low `data_len` bits only.
  - Even: the bit makes the total count of ones even. Odd: inverted.
  - Computed from the snapshot when the frame starts.
- **Configuration.** Latched per word at handshake. Input changes mid-frame do not affect the frame on the line.
- **`data_len` out of range.** Values < 5 act as 5; values > `DATA_WIDTH` act as `DATA_WIDTH`.
- **Bit timer.**
  - Counts 0..max(`prescale`,1)−1.
  - Each bit lasts exactly max(`prescale`,1) clk cycles.
  - `prescale` is sampled at each frame start.
- **Outputs.** `tx_out` is registered (glitch-free). `busy` = state ≠ IDLE.

## Timing
- **Reset values** (asynchronous, on `rstn` low): `tx_out`=1, `busy`=0, `in_ready`=1, state IDLE, buffer empty, counters 0.
- **Reset mid-frame:** the line returns high immediately and the frame is lost.
- **Idle-start latency.**
  - Handshake at edge N → buffer full after N.
  - `tx_out`=0 and `busy`=1 from edge N+1.
  - `in_ready` returns to 1 at edge N+1, when the word moves to the shifter.
- **Frame length:** (1 + `data_len` + `par_en` + 1 + `stop2`) × P cycles, where P = max(`prescale`,1).
- **Back-to-back.**
  - If the buffer is full at the end of the last stop bit, the next start bit begins on the very next cycle.
  - No idle cycle is inserted and `busy` stays 1.
- **Simultaneous events.**
  - A handshake on the last stop cycle counts as back-to-back.
  - A handshake while the buffer is being popped is not possible, because `in_ready` is 0 while the buffer is full.
- **`busy` falls** on the cycle after the last stop bit completes, when no word is pending.

## Structure
- **Package `uart_tx_pkg`:**
  - state enum (IDLE, START, DATA, PARITY, STOP);
  - `MIN_DATA_LEN`=5;
  - parity-type constants `PAR_EVEN`=0, `PAR_ODD`=1.
- **Sub-module `uart_baud_tick`:** prescale counter.
  - Inputs: `clk`, `rstn`, `clear`, `prescale`.
  - Output: `tick` on the last cycle of each bit.
- The FSM, shifter, parity and holding buffer live in the top module.

## Test plan
- **Basic 8N1.** `prescale`=4, `data_len`=8, `par_en`=0, `stop2`=0, `p_data`=0xA5 → line 0,1,0,1,0,0,1,0,1,1, each bit 4 cycles; `busy` high for 40 cycles.
- **Parity.** `data_len`=7, `par_en`=1, `p_data`=0x1FF:
  - even → parity bit 1 (seven ones);
  - odd → parity bit 0;
  - bit 8 of `p_data` is not sent.
- **Back-to-back.** Two handshakes: 0x55, then a second word accepted during the first frame → second start bit immediately follows the stop bit, with `busy` never low; `in_ready` low from the second handshake until the second frame starts.
- **Two stop bits and config isolation.**
  - `stop2`=1, `prescale`=3 → stop high for 6 cycles.
  - `stop2` and `par_en` toggled mid-frame → the current frame is unchanged.
- **Reset and edge cases.**
  - `rstn` pulsed low during DATA → `tx_out`=1, `busy`=0, `in_ready`=1 asynchronously.
  - Next frame after reset is correct.
  - `prescale`=0 → 1-cycle bits.
  - `data_len`=3 → 5 bits sent.
